tk1_spi_slave: RTL and testbench
================================

# tk1_spi_slave

SPI responder (mode 0, CPOL=0/CPHA=0, MSB first, 8-bit frames) for the tk1 subsystem, complementary to the tk1 SPI master. It lets the FPGA be addressed over SPI by an external controller, or by the on-chip master in loopback test builds. All SPI pins are asynchronous to `clk` and are oversampled through synchronizers. The host side exposes a one-byte TX holding register and a received-byte strobe.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth applied equally to `spi_ss`, `spi_sck` and `spi_mosi`. Legal range 2..3.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `spi_ss`  in  1  slave select, active low.
- `spi_sck`  in  1  SPI clock from the controller. Idle low.
- `spi_mosi`  in  1  controller-to-responder data.
- `spi_miso`  out  1  responder-to-controller data. Registered.
- `spi_miso_en`  out  1  pad output enable. High while selected.
- `selected`  out  1  synchronized select status (high = selected).
- `tx_data`  in  8  next byte to send.
- `tx_data_vld`  in  1  write strobe for `tx_data`.
- `tx_ready`  out  1  TX holding register is empty and can accept a write.
- `tx_underrun`  out  1  sticky flag: a byte load found the holding register empty.
- `underrun_clr`  in  1  clears `tx_underrun`.
- `rx_data`  out  8  last complete received byte. Held until the next byte completes.
- `rx_data_vld`  out  1  one-cycle strobe: `rx_data` has been updated.

## Operation
- Synchronized signals are `ss_s`, `sck_s` and `mosi_s`. A registered copy `sck_d` is used for edge detection: rise = `sck_s & ~sck_d`, fall = `~sck_s & sck_d`.
- Holding register `hold_reg` with flag `hold_full`. `tx_ready = ~hold_full`.
  - `tx_data_vld` with `hold_full=0`: latch `tx_data`, set `hold_full`.
  - `tx_data_vld` with `hold_full=1`: the write is ignored. No overwrite, no flag.
- Load rule: `tx_shift <= hold_full ? hold_reg : 8'h00`.
  - If `hold_full=1`, clear `hold_full`.
  - If `hold_full=0`, set `tx_underrun`.
  - If a host write occurs in the same cycle as a load that found the holding register empty, the write lands in `hold_reg` for the next byte. The load still sends 0x00 and flags underrun.
- `spi_miso = tx_shift[7]`.
- State machine:
  - **IDLE**: `spi_miso_en=0`, `spi_miso=0`.
    - On `ss_s` falling: perform the load, set `bit_ctr=0`, `edge_seen=0`, `byte_done=0`, go to ACTIVE.
  - **ACTIVE**, on `sck_s` rise:
    - `rx_shift <= {rx_shift[6:0], mosi_s}`, `bit_ctr++`, set `edge_seen`.
    - If `bit_ctr` was 7: `rx_data <= {rx_shift[6:0], mosi_s}`, pulse `rx_data_vld` next cycle, set `byte_done`, `bit_ctr` wraps to 0.
  - **ACTIVE**, on `sck_s` fall:
    - If `edge_seen=0`: ignore. This covers spurious falls and leaves bit 7 intact.
    - Else if `byte_done=1`: perform the load (back-to-back frames), clear `byte_done`.
    - Otherwise: `tx_shift <= {tx_shift[6:0], 1'b0}`.
    - In all non-ignored cases, clear `edge_seen`.
  - **ACTIVE**, on `ss_s` rising (takes priority over any same-cycle sck edge): go to IDLE.
    - A partial byte is discarded: no `rx_data_vld`, `rx_data` unchanged.
    - `tx_shift` is discarded. `hold_reg` is unchanged.
- `underrun_clr` clears `tx_underrun`. A set event in the same cycle wins.
- Reset values: `spi_miso=0`, `spi_miso_en=0`, `selected=0`, `tx_ready=1`, `tx_underrun=0`, `rx_data=8'h00`, `rx_data_vld=0`. Internal state is IDLE, counters are 0, `hold_full=0`.
- Reset asserted mid-frame aborts immediately. After release the block waits for a fresh `ss_s` falling edge. An already-low `spi_ss` at release does not start a frame.

## Timing
- Pin-to-edge-detect latency is `SYNC_STAGES+1` clk cycles.
- `spi_miso` updates `SYNC_STAGES+1` cycles after a pin-level `spi_sck` fall or `spi_ss` fall.
- `rx_data_vld` asserts `SYNC_STAGES+2` cycles after the 8th pin-level sck rise.
- Each sck high or low phase must be at least `SYNC_STAGES+2` clk cycles. The tk1 master's 16-cycle phases satisfy this.
- First MISO bit is valid `SYNC_STAGES+1` cycles after ss falls. The controller must delay the first sck rise by at least `SYNC_STAGES+2` cycles.
- `spi_miso_en` and `selected` follow `ss_s` with 1 cycle of register latency.

## Test plan
- Preload 0xA5, select, clock MOSI=0x3C with 16-cycle phases -> MISO bits 1,0,1,0,0,1,0,1; `rx_data=0x3C`; exactly one `rx_data_vld`; `tx_ready` goes 1 at the load.
- Two back-to-back bytes in one select, holding reloaded with 0x81 during byte 1 -> second MISO byte is 0x81; two strobes, second with `rx_data` = second MOSI byte; `tx_underrun=0`.
- Select with holding empty -> MISO sends 0x00, `tx_underrun=1`; `underrun_clr` -> 0; simultaneous set+clr -> stays 1.
- Deassert ss after 5 sck rises -> no strobe, `rx_data` unchanged; next frame transfers correctly from bit 7.
- Write 0x11 then 0x22 without a frame -> 0x22 ignored; next frame sends 0x11.
- Assert `reset` mid-byte, with ss held low through reset release -> all outputs return to reset values; no transfer until ss toggles high then low.

Source files
------------

// File: rtl/tk1_spi_slave_if.sv
// Bus bundle for the tk1 SPI responder: the SPI pins plus the host-side
// TX holding register and RX byte strobe. The slave modport is the
// responder's view; the master modport is the view of whatever drives it
// (an external controller model, or the host plus the on-chip SPI master).
interface tk1_spi_slave_if;
   // SPI pins
   logic       spi_ss;
   logic       spi_sck;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_miso_en;
   logic       selected;

   // Host TX side
   logic [7:0] tx_data;
   logic       tx_data_vld;
   logic       tx_ready;
   logic       tx_underrun;
   logic       underrun_clr;

   // Host RX side
   logic [7:0] rx_data;
   logic       rx_data_vld;

   modport slave (
      input  spi_ss,
      input  spi_sck,
      input  spi_mosi,
      output spi_miso,
      output spi_miso_en,
      output selected,
      input  tx_data,
      input  tx_data_vld,
      output tx_ready,
      output tx_underrun,
      input  underrun_clr,
      output rx_data,
      output rx_data_vld
   );

   modport master (
      output spi_ss,
      output spi_sck,
      output spi_mosi,
      input  spi_miso,
      input  spi_miso_en,
      input  selected,
      output tx_data,
      output tx_data_vld,
      input  tx_ready,
      input  tx_underrun,
      output underrun_clr,
      input  rx_data,
      input  rx_data_vld
   );
endinterface

// File: rtl/tk1_spi_slave.sv
// tk1 SPI responder: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
// SPI pins are asynchronous to clk and are oversampled through
// SYNC_STAGES-deep synchronizers (legal 2..3); all edge detection happens
// on the synchronized copies. A one-byte holding register feeds the TX
// shifter, and each completed RX byte is presented with a one-cycle strobe.
module tk1_spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           reset,
   tk1_spi_slave_if.slave bus
);

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_t;

   // ------------------------------------------------------------------
   // Pin synchronizers: index 2 = ss, 1 = sck, 0 = mosi.
   // The chains clear to 0 so that a slave select that is already low when
   // reset releases never looks like a falling edge; a frame can only start
   // after ss has been seen high and then low again.
   // ------------------------------------------------------------------
   logic [2:0] pin_raw;
   logic [2:0] pin_s;

   assign pin_raw = {bus.spi_ss, bus.spi_sck, bus.spi_mosi};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_q;

         // Shift the raw pin level through the synchronizer chain.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               chain_q <= '0;
            end else begin
               chain_q <= {chain_q[SYNC_STAGES-2:0], pin_raw[gi]};
            end
         end

         assign pin_s[gi] = chain_q[SYNC_STAGES-1];
      end
   endgenerate

   logic ss_s;
   logic sck_s;
   logic mosi_s;

   assign ss_s   = pin_s[2];
   assign sck_s  = pin_s[1];
   assign mosi_s = pin_s[0];

   // ------------------------------------------------------------------
   // Registers and their next-state values
   // ------------------------------------------------------------------
   state_t     state_q,       state_d;
   logic       ss_d_q;
   logic       sck_d_q;
   logic [7:0] hold_q,        hold_d;
   logic       hold_full_q,   hold_full_d;
   logic [7:0] tx_shift_q,    tx_shift_d;
   logic [7:0] rx_shift_q,    rx_shift_d;
   logic [2:0] bit_ctr_q,     bit_ctr_d;
   logic       edge_seen_q,   edge_seen_d;
   logic       byte_done_q,   byte_done_d;
   logic [7:0] rx_data_q,     rx_data_d;
   logic       rx_pend_q,     rx_pend_d;
   logic       rx_data_vld_q, rx_data_vld_d;
   logic       underrun_q,    underrun_d;

   // Edge detection on the synchronized pins.
   logic ss_fall;
   logic ss_rise;
   logic sck_rise;
   logic sck_fall;

   assign ss_fall  = ~ss_s  &  ss_d_q;
   assign ss_rise  =  ss_s  & ~ss_d_q;
   assign sck_rise =  sck_s & ~sck_d_q;
   assign sck_fall = ~sck_s &  sck_d_q;

   // Asserted in the cycle the TX shifter is (re)loaded from the holding
   // register: at frame start, and on the sck fall that ends a byte.
   logic load;

   // Next-state logic for the frame FSM, the shifters and the host registers.
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      hold_full_d   = hold_full_q;
      tx_shift_d    = tx_shift_q;
      rx_shift_d    = rx_shift_q;
      bit_ctr_d     = bit_ctr_q;
      edge_seen_d   = edge_seen_q;
      byte_done_d   = byte_done_q;
      rx_data_d     = rx_data_q;
      rx_pend_d     = 1'b0;
      rx_data_vld_d = rx_pend_q;
      underrun_d    = underrun_q;
      load          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               load        = 1'b1;
               bit_ctr_d   = 3'd0;
               edge_seen_d = 1'b0;
               byte_done_d = 1'b0;
               rx_shift_d  = 8'h00;
               state_d     = ST_ACTIVE;
            end
         end

         ST_ACTIVE: begin
            if (ss_rise) begin
               // Deselect wins over any sck edge in the same cycle. A partial
               // byte and the TX shifter contents are dropped; the holding
               // register keeps whatever the host left in it.
               state_d     = ST_IDLE;
               tx_shift_d  = 8'h00;
               bit_ctr_d   = 3'd0;
               edge_seen_d = 1'b0;
               byte_done_d = 1'b0;
            end else if (sck_rise) begin
               rx_shift_d  = {rx_shift_q[6:0], mosi_s};
               bit_ctr_d   = bit_ctr_q + 3'd1;
               edge_seen_d = 1'b1;
               if (bit_ctr_q == 3'd7) begin
                  rx_data_d   = {rx_shift_q[6:0], mosi_s};
                  rx_pend_d   = 1'b1;
                  byte_done_d = 1'b1;
               end
            end else if (sck_fall && edge_seen_q) begin
               // A fall with no preceding rise in this bit (e.g. sck already
               // high at select) is ignored so that bit 7 is not shifted out
               // before the controller has sampled it.
               edge_seen_d = 1'b0;
               if (byte_done_q) begin
                  load        = 1'b1;
                  byte_done_d = 1'b0;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Loading from an empty holding register sends zeros and flags it.
      if (load) begin
         tx_shift_d = hold_full_q ? hold_q : 8'h00;
         if (hold_full_q) begin
            hold_full_d = 1'b0;
         end
      end

      // Host writes only land in an empty holding register. A write in the
      // same cycle as an empty-register load is kept for the next byte.
      if (bus.tx_data_vld && !hold_full_q) begin
         hold_d      = bus.tx_data;
         hold_full_d = 1'b1;
      end

      // Clear first so that a simultaneous underrun event wins.
      if (bus.underrun_clr) begin
         underrun_d = 1'b0;
      end
      if (load && !hold_full_q) begin
         underrun_d = 1'b1;
      end
   end

   // State and datapath registers; everything returns to idle/empty on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ss_d_q        <= 1'b0;
         sck_d_q       <= 1'b0;
         hold_q        <= 8'h00;
         hold_full_q   <= 1'b0;
         tx_shift_q    <= 8'h00;
         rx_shift_q    <= 8'h00;
         bit_ctr_q     <= 3'd0;
         edge_seen_q   <= 1'b0;
         byte_done_q   <= 1'b0;
         rx_data_q     <= 8'h00;
         rx_pend_q     <= 1'b0;
         rx_data_vld_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ss_d_q        <= ss_s;
         sck_d_q       <= sck_s;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         tx_shift_q    <= tx_shift_d;
         rx_shift_q    <= rx_shift_d;
         bit_ctr_q     <= bit_ctr_d;
         edge_seen_q   <= edge_seen_d;
         byte_done_q   <= byte_done_d;
         rx_data_q     <= rx_data_d;
         rx_pend_q     <= rx_pend_d;
         rx_data_vld_q <= rx_data_vld_d;
         underrun_q    <= underrun_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs. The FSM state is itself a register that follows ss_s by one
   // cycle, so it directly provides the pad enable and select status.
   // The TX shifter is cleared whenever the frame ends, so MISO idles low.
   // ------------------------------------------------------------------
   assign bus.spi_miso    = tx_shift_q[7];
   assign bus.spi_miso_en = (state_q == ST_ACTIVE);
   assign bus.selected    = (state_q == ST_ACTIVE);
   assign bus.tx_ready    = ~hold_full_q;
   assign bus.tx_underrun = underrun_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_data_vld = rx_data_vld_q;

endmodule

// File: tb/tb_tk1_spi_slave.sv
// Directed bench for tk1_spi_slave: a table of single-byte frames plus
// hand-written sequences for back-to-back bytes, underrun set/clear race,
// aborted frames, ignored host writes and reset in the middle of a byte.
`timescale 1ns/1ps
module tb_tk1_spi_slave;
   localparam int PH = 16;   // sck half period in clk cycles

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tk1_spi_slave_if bus();

   tk1_spi_slave #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Free-running cycle count and RX strobe monitor.
   int         cyc = 0;
   int         strobe_cnt = 0;
   int         strobe_cyc = 0;
   int         last_rise_cyc = 0;
   logic [7:0] strobe_rx = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rx_data_vld === 1'b1) begin
         strobe_cnt <= strobe_cnt + 1;
         strobe_rx  <= bus.rx_data;
         strobe_cyc <= cyc;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic host_write(input logic [7:0] b);
      bus.tx_data     = b;
      bus.tx_data_vld = 1'b1;
      cycles(1);
      bus.tx_data_vld = 1'b0;
   endtask

   task automatic clr_pulse();
      bus.underrun_clr = 1'b1;
      cycles(1);
      bus.underrun_clr = 1'b0;
   endtask

   task automatic ss_low();
      bus.spi_ss = 1'b0;
      cycles(PH);
   endtask

   task automatic ss_high();
      cycles(PH);
      bus.spi_ss = 1'b1;
      cycles(PH);
   endtask

   // Mode-0 controller: present MOSI, sample MISO just before the rise,
   // then return sck low. Sends the top n bits of b.
   task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] m);
      m = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         bus.spi_mosi = b[i];
         cycles(PH);
         m[i] = bus.spi_miso;
         bus.spi_sck   = 1'b1;
         last_rise_cyc = cyc;
         cycles(PH);
         bus.spi_sck = 1'b0;
      end
   endtask

   typedef struct {
      logic       pre_en;
      logic [7:0] pre;
      logic       post_en;   // host refills the holding register mid-byte
      logic [7:0] post;
      logic [7:0] mosi;
      logic [7:0] exp_miso;
      logic       exp_und;   // underrun after the frame
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic [7:0] m;
      logic [7:0] m2;
      int s0;

      // Every single-byte frame ends with an sck fall after the 8th rise,
      // which reloads the shifter; without a mid-byte refill that reload
      // finds the holding register empty and raises the underrun flag.
      vecs[0] = '{1'b1, 8'hA5, 1'b1, 8'h5A, 8'h3C, 8'hA5, 1'b0};
      vecs[1] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1};
      vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h11, 8'hFF, 8'h00, 1'b1};
      vecs[3] = '{1'b1, 8'h00, 1'b1, 8'h22, 8'hC3, 8'h00, 1'b0};
      vecs[4] = '{1'b1, 8'h81, 1'b1, 8'h99, 8'h7E, 8'h81, 1'b0};

      reset            = 1'b1;
      bus.spi_ss       = 1'b1;
      bus.spi_sck      = 1'b0;
      bus.spi_mosi     = 1'b0;
      bus.tx_data      = 8'h00;
      bus.tx_data_vld  = 1'b0;
      bus.underrun_clr = 1'b0;
      cycles(3);

      check("rst miso",     bus.spi_miso,    0);
      check("rst miso_en",  bus.spi_miso_en, 0);
      check("rst selected", bus.selected,    0);
      check("rst tx_ready", bus.tx_ready,    1);
      check("rst underrun", bus.tx_underrun, 0);
      check("rst rx_data",  bus.rx_data,     0);
      check("rst rx_vld",   bus.rx_data_vld, 0);
      reset = 1'b0;
      cycles(PH);

      // ---------------- table-driven single-byte frames ----------------
      for (int v = 0; v < 5; v++) begin
         clr_pulse();
         check($sformatf("v%0d und cleared", v), bus.tx_underrun, 0);
         if (vecs[v].pre_en) begin
            host_write(vecs[v].pre);
            check($sformatf("v%0d ready after write", v), bus.tx_ready, 0);
         end
         s0 = strobe_cnt;
         ss_low();
         check($sformatf("v%0d sel/en", v), {bus.selected, bus.spi_miso_en}, 2'b11);
         check($sformatf("v%0d ready after load", v), bus.tx_ready, 1);
         if (vecs[v].post_en) host_write(vecs[v].post);
         send_bits(vecs[v].mosi, 8, m);
         ss_high();
         check($sformatf("v%0d miso byte", v), m, vecs[v].exp_miso);
         check($sformatf("v%0d rx_data", v), bus.rx_data, vecs[v].mosi);
         check($sformatf("v%0d strobes", v), strobe_cnt - s0, 1);
         check($sformatf("v%0d strobe data", v), strobe_rx, vecs[v].mosi);
         check($sformatf("v%0d vld latency", v), strobe_cyc - last_rise_cyc, 4);
         check($sformatf("v%0d underrun", v), bus.tx_underrun, vecs[v].exp_und);
         check($sformatf("v%0d ready end", v), bus.tx_ready, 1);
         check($sformatf("v%0d desel", v), {bus.selected, bus.spi_miso_en}, 2'b00);
      end

      // ---------------- back-to-back bytes in one select ----------------
      clr_pulse();
      host_write(8'hC3);
      s0 = strobe_cnt;
      ss_low();
      host_write(8'h81);
      send_bits(8'h12, 8, m);
      cycles(6);
      check("b2b miso byte1", m, 8'hC3);
      check("b2b und after reload", bus.tx_underrun, 0);
      check("b2b ready after reload", bus.tx_ready, 1);
      check("b2b strobes byte1", strobe_cnt - s0, 1);
      check("b2b strobe data1", strobe_rx, 8'h12);
      send_bits(8'h34, 8, m2);
      ss_high();
      check("b2b miso byte2", m2, 8'h81);
      check("b2b strobes byte2", strobe_cnt - s0, 2);
      check("b2b strobe data2", strobe_rx, 8'h34);
      check("b2b rx_data", bus.rx_data, 8'h34);
      check("b2b und final reload", bus.tx_underrun, 1);

      // ---------------- underrun set and clear in the same cycle ----------------
      clr_pulse();
      check("und clr", bus.tx_underrun, 0);
      bus.spi_ss = 1'b0;
      cycles(2);                 // ss pin -> load after 3 clk edges
      bus.underrun_clr = 1'b1;   // held across the load edge
      cycles(1);
      bus.underrun_clr = 1'b0;
      check("und set beats clr", bus.tx_underrun, 1);
      cycles(PH);
      clr_pulse();
      check("und clr again", bus.tx_underrun, 0);
      bus.spi_ss = 1'b1;
      cycles(PH);

      // ---------------- aborted frame after 5 rises ----------------
      host_write(8'h6D);
      s0 = strobe_cnt;
      ss_low();
      send_bits(8'hF0, 5, m);
      ss_high();
      check("abort miso bits", m, 8'h68);
      check("abort no strobe", strobe_cnt - s0, 0);
      check("abort rx kept", bus.rx_data, 8'h34);
      host_write(8'hB4);
      s0 = strobe_cnt;
      ss_low();
      send_bits(8'h96, 8, m);
      ss_high();
      check("after abort miso", m, 8'hB4);
      check("after abort rx", bus.rx_data, 8'h96);
      check("after abort strobes", strobe_cnt - s0, 1);

      // ---------------- second write while full is dropped ----------------
      host_write(8'h11);
      check("full ready", bus.tx_ready, 0);
      host_write(8'h22);
      check("full still", bus.tx_ready, 0);
      ss_low();
      send_bits(8'h5A, 8, m);
      ss_high();
      check("dropped write miso", m, 8'h11);
      check("dropped write rx", bus.rx_data, 8'h5A);

      // ---------------- reset in the middle of a byte ----------------
      host_write(8'hF7);
      ss_low();
      host_write(8'h4B);
      send_bits(8'hC5, 3, m);
      bus.spi_sck = 1'b1;
      cycles(4);
      check("mid sel", bus.selected, 1);
      check("mid miso", bus.spi_miso, 1);
      reset = 1'b1;
      cycles(2);
      check("mrst miso",     bus.spi_miso,    0);
      check("mrst miso_en",  bus.spi_miso_en, 0);
      check("mrst selected", bus.selected,    0);
      check("mrst tx_ready", bus.tx_ready,    1);
      check("mrst underrun", bus.tx_underrun, 0);
      check("mrst rx_data",  bus.rx_data,     0);
      check("mrst rx_vld",   bus.rx_data_vld, 0);
      bus.spi_sck = 1'b0;
      cycles(2);
      reset = 1'b0;              // ss still low at release
      cycles(PH);
      check("post rst idle", bus.selected, 0);
      s0 = strobe_cnt;
      send_bits(8'hFF, 8, m);
      cycles(PH);
      check("post rst miso", m, 8'h00);
      check("post rst no strobe", strobe_cnt - s0, 0);
      check("post rst rx", bus.rx_data, 8'h00);
      check("post rst still idle", bus.selected, 0);
      bus.spi_ss = 1'b1;
      cycles(PH);
      host_write(8'h3E);
      s0 = strobe_cnt;
      ss_low();
      send_bits(8'hA1, 8, m);
      ss_high();
      check("fresh frame miso", m, 8'h3E);
      check("fresh frame rx", bus.rx_data, 8'hA1);
      check("fresh frame strobes", strobe_cnt - s0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
